// File: rtl/tiny_mult_pipe_pkg.sv
// Shared types and default geometry for the pipelined multiply / multiply-accumulate block.
// Constants and helpers only: no latency, no backpressure.
package tiny_mult_pkg;

   typedef enum logic [1:0] {
      MODE_UMUL = 2'b00,
      MODE_SMUL = 2'b01,
      MODE_UMAC = 2'b10,
      MODE_SMAC = 2'b11
   } mult_mode_e;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_LATENCY = 3;
   localparam int DEF_GUARD   = 4;

   function automatic logic mode_is_signed(input mult_mode_e m);
      return (m == MODE_SMUL) || (m == MODE_SMAC);
   endfunction

   function automatic logic mode_is_mac(input mult_mode_e m);
      return (m == MODE_UMAC) || (m == MODE_SMAC);
   endfunction

endpackage

// File: rtl/tiny_mult_pipe_if.sv
// Issue/complete bundle between a requester and tiny_mult_pipe.
// No latency of its own; the pipe accepts one start per cycle and never stalls.
interface tiny_mult_pipe_if import tiny_mult_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int GUARD = DEF_GUARD
);
   localparam int RES_W = 2*WIDTH + GUARD;

   logic               start;
   mult_mode_e         mode;
   logic [WIDTH-1:0]   A;
   logic [WIDTH-1:0]   B;
   logic               acc_clr;
   logic               done;
   logic [RES_W-1:0]   result;
   logic               ovf;

   modport master (output start, mode, A, B, acc_clr, input  done, result, ovf);
   modport slave  (input  start, mode, A, B, acc_clr, output done, result, ovf);

endinterface

// File: rtl/tiny_mult_pipe_valid_pipe.sv
// LATENCY-deep {valid, mode} shift register tracking each issued op; synchronous clear on rst.
// Latency LATENCY cycles from i_vld to o_done; no backpressure, accepts every cycle.
module valid_pipe import tiny_mult_pkg::*; #(
   parameter int LATENCY = DEF_LATENCY
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_vld,
   input  mult_mode_e i_mode,
   output mult_mode_e o_mode_s1,
   output logic       o_vld_fin,
   output mult_mode_e o_mode_fin,
   output logic       o_done
);
   logic [LATENCY:1] r_vld;
   mult_mode_e       r_mode [1:LATENCY];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         for (int k = 1; k <= LATENCY; k++) r_mode[k] <= MODE_UMUL;
      end else begin
         r_vld <= {r_vld[LATENCY-1:1], i_vld};
         // mode only moves with a live op, so stage 1 doubles as the held mode register
         if (i_vld) r_mode[1] <= i_mode;
         for (int k = 2; k <= LATENCY; k++) begin
            if (r_vld[k-1]) r_mode[k] <= r_mode[k-1];
         end
      end
   end

   assign o_mode_s1  = r_mode[1];
   assign o_vld_fin  = r_vld[LATENCY-1];
   assign o_mode_fin = r_mode[LATENCY-1];
   assign o_done     = r_vld[LATENCY];

endmodule

// File: rtl/tiny_mult_pipe.sv
// Fully pipelined unsigned/signed multiply and multiply-accumulate with sticky overflow.
// Latency LATENCY cycles start->done; no backpressure, one start accepted every cycle.
module tiny_mult_pipe import tiny_mult_pkg::*; #(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int LATENCY = DEF_LATENCY,
   parameter int GUARD   = DEF_GUARD
) (
   input  logic           clk,
   input  logic           rst,
   tiny_mult_pipe_if.slave bus
);
   localparam int RES_W = 2*WIDTH + GUARD;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   mult_mode_e       w_mode_s1;
   mult_mode_e       w_mode_fin;
   logic             w_vld_fin;
   logic             w_done;
   logic             w_sgn_s1;
   logic [RES_W-1:0] w_a_ext;
   logic [RES_W-1:0] w_b_ext;
   logic [RES_W-1:0] w_prod;
   logic [RES_W-1:0] w_prod_fin;
   logic [RES_W-1:0] w_base;
   logic [RES_W:0]   w_sum;
   logic             w_mac;
   logic             w_add_ovf;
   logic [RES_W-1:0] r_acc;
   logic [RES_W-1:0] r_res;
   logic             r_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a <= '0;
         r_b <= '0;
      end else if (bus.start) begin
         r_a <= bus.A;
         r_b <= bus.B;
      end
   end

   valid_pipe #(.LATENCY(LATENCY)) u_valid_pipe (
      .clk        (clk),
      .rst        (rst),
      .i_vld      (bus.start),
      .i_mode     (bus.mode),
      .o_mode_s1  (w_mode_s1),
      .o_vld_fin  (w_vld_fin),
      .o_mode_fin (w_mode_fin),
      .o_done     (w_done)
   );

   // Extending before multiplying gives the correctly signed product modulo 2^RES_W.
   assign w_sgn_s1 = mode_is_signed(w_mode_s1);
   assign w_a_ext  = {{(RES_W-WIDTH){w_sgn_s1 & r_a[WIDTH-1]}}, r_a};
   assign w_b_ext  = {{(RES_W-WIDTH){w_sgn_s1 & r_b[WIDTH-1]}}, r_b};
   assign w_prod   = w_a_ext * w_b_ext;

   generate
      if (LATENCY == 2) begin : g_prod_direct
         assign w_prod_fin = w_prod;
      end else begin : g_prod_pipe
         logic [RES_W-1:0] r_prod [LATENCY-2];
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int k = 0; k < LATENCY-2; k++) r_prod[k] <= '0;
            end else begin
               r_prod[0] <= w_prod;
               for (int k = 1; k < LATENCY-2; k++) r_prod[k] <= r_prod[k-1];
            end
         end
         assign w_prod_fin = r_prod[LATENCY-3];
      end
   endgenerate

   // Clear-then-add: a coincident acc_clr makes the product the new accumulator.
   assign w_mac     = w_vld_fin & mode_is_mac(w_mode_fin);
   assign w_base    = bus.acc_clr ? '0 : r_acc;
   assign w_sum     = {1'b0, w_base} + {1'b0, w_prod_fin};
   assign w_add_ovf = mode_is_signed(w_mode_fin)
                    ? ((w_base[RES_W-1] == w_prod_fin[RES_W-1]) && (w_sum[RES_W-1] != w_base[RES_W-1]))
                    : w_sum[RES_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
         r_res <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_mac) r_acc <= w_sum[RES_W-1:0];
         else if (bus.acc_clr) r_acc <= '0;
         if (w_vld_fin) r_res <= w_mac ? w_sum[RES_W-1:0] : w_prod_fin;
         r_ovf <= (r_ovf & ~bus.acc_clr) | (w_mac & w_add_ovf);
      end
   end

   assign bus.done   = w_done;
   assign bus.result = r_res;
   assign bus.ovf    = r_ovf;

endmodule

// File: tb/tb_tiny_mult_pipe.sv
// Bench for tiny_mult_pipe: arithmetic reference model compared every cycle, plus pinned directed values.
module tb_tiny_mult_pipe;
   import tiny_mult_pkg::*;

   localparam int     WIDTH = 8;
   localparam int     LAT   = 3;
   localparam int     GUARD = 4;
   localparam int     RES_W = 2*WIDTH + GUARD;
   localparam longint M     = longint'(1) << RES_W;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   tiny_mult_pipe_if #(.WIDTH(WIDTH), .GUARD(GUARD)) bus ();

   tiny_mult_pipe #(.WIDTH(WIDTH), .LATENCY(LAT), .GUARD(GUARD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: queue of issued ops, each retiring LAT cycles after issue.
   typedef struct {
      logic [1:0] mode;
      longint     a;
      longint     b;
      longint     due;
   } op_t;

   op_t    q[$];
   longint edge_n = 0;
   longint m_acc = 0;
   longint m_res = 0;
   bit     m_ovf = 0;
   bit     m_done = 0;
   bit     model_live = 0;

   function automatic longint sval(input longint v, input int w);
      return (v >= (longint'(1) << (w-1))) ? v - (longint'(1) << w) : v;
   endfunction

   function automatic longint wrap(input longint v);
      return ((v % M) + M) % M;
   endfunction

   always @(posedge clk) begin : model
      op_t    op;
      longint pa, pb, prod, base, s;
      bit     clr;
      edge_n     = edge_n + 1;
      model_live = 1;
      clr        = bus.acc_clr;
      if (rst) begin
         q.delete();
         m_acc = 0; m_res = 0; m_ovf = 0; m_done = 0;
      end else begin
         m_done = 0;
         if (q.size() > 0 && q[0].due == edge_n) begin
            op     = q.pop_front();
            m_done = 1;
            pa     = op.mode[0] ? sval(op.a, WIDTH) : op.a;
            pb     = op.mode[0] ? sval(op.b, WIDTH) : op.b;
            prod   = pa * pb;
            if (op.mode[1]) begin
               base = clr ? 0 : m_acc;
               if (clr) m_ovf = 0;
               s = (op.mode[0] ? sval(base, RES_W) : base) + prod;
               if (op.mode[0] ? (s > M/2 - 1 || s < -(M/2)) : (s >= M)) m_ovf = 1;
               m_acc = wrap(s);
               m_res = m_acc;
            end else begin
               m_res = wrap(prod);
               if (clr) begin m_acc = 0; m_ovf = 0; end
            end
         end else if (clr) begin
            m_acc = 0; m_ovf = 0;
         end
         if (bus.start) begin
            op.mode = bus.mode;
            op.a    = longint'(bus.A);
            op.b    = longint'(bus.B);
            op.due  = edge_n + LAT - 1;
            q.push_back(op);
         end
      end
   end

   always @(negedge clk) begin
      if (model_live) begin
         chk("model.done",   32'(bus.done),   32'(m_done));
         chk("model.result", 32'(bus.result), 32'(m_res));
         chk("model.ovf",    32'(bus.ovf),    32'(m_ovf));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input mult_mode_e m, input logic [7:0] a, input logic [7:0] b);
      bus.start = 1'b1;
      bus.mode  = m;
      bus.A     = a;
      bus.B     = b;
      step();
      bus.start = 1'b0;
   endtask

   task automatic clr();
      bus.acc_clr = 1'b1;
      step();
      bus.acc_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.mode = MODE_UMUL; bus.A = '0; bus.B = '0; bus.acc_clr = 1'b0;
      step(); step();
      chk("rst.done",   32'(bus.done),   32'd0);
      chk("rst.result", 32'(bus.result), 32'd0);
      chk("rst.ovf",    32'(bus.ovf),    32'd0);
      rst = 1'b0;
      step();

      // unsigned 0xFF*0xFF, done exactly three cycles after issue
      go(MODE_UMUL, 8'hFF, 8'hFF);
      chk("umul.c1.done", 32'(bus.done), 32'd0);
      step();
      chk("umul.c2.done", 32'(bus.done), 32'd0);
      step();
      chk("umul.c3.done",   32'(bus.done),   32'd1);
      chk("umul.c3.result", 32'(bus.result), 32'h0FE01);
      chk("umul.c3.ovf",    32'(bus.ovf),    32'd0);
      step();
      chk("umul.c4.done",   32'(bus.done),   32'd0);
      chk("umul.c4.hold",   32'(bus.result), 32'h0FE01);

      go(MODE_SMUL, 8'hFF, 8'h02);
      step(); step();
      chk("smul.done",   32'(bus.done),   32'd1);
      chk("smul.result", 32'(bus.result), 32'hFFFFE);

      // back-to-back issue
      go(MODE_UMUL, 8'd2, 8'd3);
      go(MODE_UMUL, 8'd4, 8'd5);
      go(MODE_UMUL, 8'd6, 8'd7);
      chk("b2b.r0", 32'(bus.result), 32'd6);
      step();
      chk("b2b.r1", 32'(bus.result), 32'd20);
      step();
      chk("b2b.r2",   32'(bus.result), 32'd42);
      chk("b2b.d2",   32'(bus.done),   32'd1);
      step();
      chk("b2b.hold", 32'(bus.result), 32'd42);
      chk("b2b.idle", 32'(bus.done),   32'd0);

      // accumulate, then clear coincident with a completing MAC
      clr();
      go(MODE_UMAC, 8'd10, 8'd10);
      go(MODE_UMAC, 8'd10, 8'd10);
      go(MODE_UMAC, 8'd10, 8'd10);
      chk("mac.100", 32'(bus.result), 32'd100);
      step();
      chk("mac.200", 32'(bus.result), 32'd200);
      step();
      chk("mac.300", 32'(bus.result), 32'd300);
      go(MODE_UMAC, 8'd5, 8'd5);
      step();
      bus.acc_clr = 1'b1;
      step();
      bus.acc_clr = 1'b0;
      chk("macclr.done",   32'(bus.done),   32'd1);
      chk("macclr.result", 32'(bus.result), 32'd25);
      chk("macclr.ovf",    32'(bus.ovf),    32'd0);

      // unsigned accumulator overflow and stickiness
      clr();
      for (int i = 0; i < 17; i++) go(MODE_UMAC, 8'hFF, 8'hFF);
      step();
      chk("ovf.r16", 32'(bus.result), 32'd1040400);
      chk("ovf.o16", 32'(bus.ovf),    32'd0);
      step();
      chk("ovf.r17", 32'(bus.result), 32'd56849);
      chk("ovf.o17", 32'(bus.ovf),    32'd1);
      go(MODE_UMUL, 8'd3, 8'd4);
      step(); step();
      chk("ovf.mul.result", 32'(bus.result), 32'd12);
      chk("ovf.mul.sticky", 32'(bus.ovf),    32'd1);
      clr();
      chk("ovf.cleared", 32'(bus.ovf), 32'd0);

      // mixed-mode stream and signed accumulation past the positive limit
      clr();
      go(MODE_SMAC, 8'h80, 8'h7F);
      go(MODE_UMUL, 8'hFF, 8'h01);
      go(MODE_SMUL, 8'h7F, 8'h80);
      go(MODE_UMAC, 8'h02, 8'h03);
      go(MODE_SMAC, 8'hFE, 8'h05);
      for (int i = 0; i < 4; i++) step();
      clr();
      for (int i = 0; i < 33; i++) go(MODE_SMAC, 8'h80, 8'h80);
      for (int i = 0; i < 4; i++) step();

      // reset while an op is in flight
      go(MODE_UMUL, 8'd9, 8'd9);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstmid.done",   32'(bus.done),   32'd0);
      chk("rstmid.result", 32'(bus.result), 32'd0);
      chk("rstmid.ovf",    32'(bus.ovf),    32'd0);
      step();
      chk("rstmid.flushed", 32'(bus.done), 32'd0);
      go(MODE_UMUL, 8'd3, 8'd3);
      chk("rstmid.c4", 32'(bus.done), 32'd0);
      step(); step();
      chk("rstmid.new.done",   32'(bus.done),   32'd1);
      chk("rstmid.new.result", 32'(bus.result), 32'd9);

      for (int i = 0; i < 3; i++) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tiny_mult_pipe.md
TINY_MULT_PIPE -- requirements
Module: tiny_mult_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, range 2..32.
REQ-002 Parameter LATENCY, default 3: cycles from start to done, range 2..8.
REQ-003 Parameter GUARD, default 4: accumulator guard bits; RES_W = 2*WIDTH+GUARD.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 start  input  1  issue one operation this cycle.
REQ-007 mode  input  2  00 unsigned mul, 01 signed mul, 10 unsigned MAC, 11 signed MAC.
REQ-008 A  input  WIDTH  operand A.
REQ-009 B  input  WIDTH  operand B.
REQ-010 acc_clr  input  1  clear the accumulator and the overflow flag.
REQ-011 done  output  1  one-cycle pulse, one per issued operation.
REQ-012 result  output  RES_W  result of the most recently completed operation.
REQ-013 ovf  output  1  sticky accumulator overflow flag.

Function
REQ-014 A, B and mode SHALL be captured only in a cycle with start=1; operand registers SHALL hold otherwise.
REQ-015 An operation issued in cycle n SHALL assert done in exactly cycle n+LATENCY, for every legal LATENCY.
REQ-016 Issue SHALL be fully pipelined: start may be high every cycle, and each start SHALL produce its own done, in issue order.
REQ-017 Mode 00: result = zero-extended A*B. Mode 01: result = sign-extended two's-complement A*B.
REQ-018 Modes 10/11: in the done cycle the accumulator SHALL add the product, extended per the signedness in REQ-017; result = new accumulator value, modulo 2^RES_W.
REQ-019 Mul modes SHALL leave the accumulator unchanged.
REQ-020 result SHALL update only in a done cycle and hold its value between done pulses.
REQ-021 acc_clr sampled high SHALL zero the accumulator and ovf at that edge.
REQ-022 acc_clr coincident with a completing MAC: accumulator := product (clear-then-add), and ovf := 0.
REQ-023 ovf SHALL set when a MAC add overflows RES_W. Unsigned overflow: carry-out. Signed overflow: operand signs equal and sum sign differs.
REQ-024 ovf SHALL stay set until acc_clr or rst.
REQ-025 Mode is carried per operation, so mixed-mode back-to-back streams SHALL complete correctly.

Reset
REQ-026 rst sampled high SHALL clear every pipeline valid bit, the operand and mode registers, the accumulator, result, done and ovf to 0.
REQ-027 Operations in flight when rst is asserted SHALL be discarded and SHALL never assert done.
REQ-028 start coincident with rst SHALL be ignored.
REQ-029 rst SHALL take priority over start and acc_clr.

Structure
REQ-030 Package tiny_mult_pkg SHALL hold:
  - the mult_mode_e typedef for the four modes;
  - the default WIDTH, LATENCY and GUARD constants.
REQ-031 Sub-module valid_pipe SHALL be a parametrised LATENCY-deep shift register carrying {valid, mode}, with synchronous clear on rst.
REQ-032 Multiplier pipelining SHALL be placed so that total latency equals LATENCY; the accumulate step is in the final stage.

Verification (WIDTH=8, LATENCY=3, GUARD=4, RES_W=20)
REQ-033 Unsigned mul: mode 00, A=0xFF, B=0xFF, start in cycle 0.
  - done in cycle 3 only; result=0x0FE01; ovf=0.
REQ-034 Signed mul: mode 01, A=0xFF, B=0x02.
  - result=0xFFFFE (-2).
REQ-035 Back-to-back: mode 00, starts in cycles 0,1,2 with (2,3), (4,5), (6,7).
  - done in cycles 3,4,5; results 6, 20, 42; result holds 42 in cycle 6.
REQ-036 MAC sequence: acc_clr, then mode 10 issues 10*10 three times.
  - results 100, 200, 300.
  - Then issue 5*5 with acc_clr coincident with its done: result=25.
REQ-037 Overflow: after acc_clr, issue 17 MACs of 255*255, mode 10.
  - 16th result=1040400 with ovf=0.
  - 17th result=56849 with ovf=1.
  - ovf stays 1 through a following mode 00 op; cleared by acc_clr.
REQ-038 Reset mid-op: start in cycle 0, rst high in cycle 1.
  - done never asserts; result=0, ovf=0.
  - A new start in cycle 3 completes normally in cycle 6.
